// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester round-robin arbiter in front of one single-port memory slave.
//   Requester 0 is the instruction side and requester 1 is the data side.
//   A transaction spends one IDLE cycle on arbitration. It then stays in a GRANT
//   state until one of three things happens:
//     - the slave completes the access (s_ready_i),
//     - the requester withdraws its request (no response is given), or
//     - the wait reaches TIMEOUT_CYCLES. The requester then receives ERR_DATA and
//       err_o pulses for one cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m{0,1}_valid_i             request valid (held until the matching ready_o)
//   m{0,1}_addr_i/_wdata_i/_we_i  request payload (we == 0 means read)
//   m{0,1}_ready_o             one-cycle completion strobe
//   m{0,1}_rdata_o             read data, meaningful while ready_o is high
//   s_valid_o/_addr_o/_wdata_o/_we_o  request muxed to the slave
//   s_ready_i, s_rdata_i       slave completion and read data
//   err_o                      one-cycle pulse on a timeout
module mem_port_arbiter #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_valid_i,
   output logic                  m0_ready_o,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   input  logic [3:0]            m0_we_i,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   input  logic                  m1_valid_i,
   output logic                  m1_ready_o,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   input  logic [3:0]            m1_we_i,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  s_valid_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_wdata_o,
   output logic [3:0]            s_we_o,
   input  logic                  s_ready_i,
   input  logic [DATA_WIDTH-1:0] s_rdata_i,
   output logic                  err_o
);

   localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TO_CNT = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e        state_q;
   logic          last_grant_q;
   logic [CW-1:0] cnt_q;

   logic granted, sel, sel_valid, timeout, done_ok, done_to;

   // IDLE drives every output to zero. Reset forces the FSM to IDLE
   // asynchronously, so all outputs are zero for the whole of reset.
   always_comb begin
      granted   = (state_q == GRANT0) || (state_q == GRANT1);
      sel       = (state_q == GRANT1);
      sel_valid = granted && (sel ? m1_valid_i : m0_valid_i);
      timeout   = (cnt_q == TO_CNT);
      // A slave completion in the timeout cycle wins over the abort.
      done_ok   = sel_valid && s_ready_i;
      done_to   = sel_valid && timeout && !s_ready_i;
   end

   always_comb begin
      s_valid_o  = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      s_we_o     = '0;
      m0_ready_o = 1'b0;
      m1_ready_o = 1'b0;
      m0_rdata_o = '0;
      m1_rdata_o = '0;
      err_o      = done_to;
      if (granted) begin
         // The request is withdrawn from the slave in the abort cycle.
         s_valid_o = sel_valid && !timeout;
         if (sel) begin
            s_addr_o   = m1_addr_i;
            s_wdata_o  = m1_wdata_i;
            s_we_o     = m1_we_i;
            m1_ready_o = done_ok || done_to;
            m1_rdata_o = done_to ? ERR_DATA : s_rdata_i;
         end else begin
            s_addr_o   = m0_addr_i;
            s_wdata_o  = m0_wdata_i;
            s_we_o     = m0_we_i;
            m0_ready_o = done_ok || done_to;
            m0_rdata_o = done_to ? ERR_DATA : s_rdata_i;
         end
      end
   end

   // last_grant resets to 1 so that requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (m0_valid_i && m1_valid_i)
                  state_q <= last_grant_q ? GRANT0 : GRANT1;
               else if (m0_valid_i)
                  state_q <= GRANT0;
               else if (m1_valid_i)
                  state_q <= GRANT1;
            end
            GRANT0, GRANT1: begin
               if (!sel_valid) begin
                  // Request withdrawn: drop it silently and keep fairness history.
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (done_ok || done_to) begin
                  state_q      <= IDLE;
                  last_grant_q <= sel;
                  cnt_q        <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_valid_i = 1'b0, m1_valid_i = 1'b0;
   logic          m0_ready_o, m1_ready_o;
   logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
   logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
   logic [3:0]    m0_we_i = '0, m1_we_i = '0;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          s_valid_o;
   logic [AW-1:0] s_addr_o;
   logic [DW-1:0] s_wdata_o;
   logic [3:0]    s_we_o;
   logic          s_ready_i = 1'b0;
   logic [DW-1:0] s_rdata_i = '0;
   logic          err_o;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid_i(m0_valid_i), .m0_ready_o(m0_ready_o), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_we_i(m0_we_i), .m0_rdata_o(m0_rdata_o),
      .m1_valid_i(m1_valid_i), .m1_ready_o(m1_ready_o), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_we_i(m1_we_i), .m1_rdata_o(m1_rdata_o),
      .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_we_o(s_we_o),
      .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset: outputs zero even with a request pending
      m0_valid_i = 1'b1; m0_addr_i = 32'h100; s_ready_i = 1'b1;
      nxt(); nxt(); settle();
      chk("rst_s_valid", s_valid_o, 0);
      chk("rst_s_addr",  s_addr_o, 0);
      chk("rst_m0_ready", m0_ready_o, 0);
      chk("rst_err", err_o, 0);
      m0_valid_i = 1'b0; s_ready_i = 1'b0; rst_n = 1'b1;
      nxt();

      // Single read from m0
      m0_valid_i = 1'b1; m0_addr_i = 32'h100; m0_we_i = 4'h0;
      settle(); chk("t1_c0_s_valid", s_valid_o, 0);
      nxt(); settle();
      chk("t1_c1_s_valid", s_valid_o, 1);
      chk("t1_c1_s_addr", s_addr_o, 32'h100);
      chk("t1_c1_m0_ready", m0_ready_o, 0);
      nxt();
      s_ready_i = 1'b1; s_rdata_i = 32'h1234_5678; settle();
      chk("t1_c2_m0_ready", m0_ready_o, 1);
      chk("t1_c2_m0_rdata", m0_rdata_o, 32'h1234_5678);
      chk("t1_c2_m1_ready", m1_ready_o, 0);
      chk("t1_c2_err", err_o, 0);
      nxt();
      m0_valid_i = 1'b0; s_ready_i = 1'b0; settle();
      chk("t1_c3_s_valid", s_valid_o, 0);
      chk("t1_c3_m0_ready", m0_ready_o, 0);

      // Both valid from reset, slave always ready: strict alternation
      rst_n = 1'b0;
      m0_valid_i = 1'b1; m0_addr_i = 32'h40;
      m1_valid_i = 1'b1; m1_addr_i = 32'h80;
      s_ready_i = 1'b1;
      nxt();
      rst_n = 1'b1; settle();
      chk("t2_c0_m0_ready", m0_ready_o, 0);
      chk("t2_c0_m1_ready", m1_ready_o, 0);
      for (int i = 1; i <= 8; i++) begin
         nxt(); settle();
         chk($sformatf("t2_c%0d_m0_ready", i), m0_ready_o, (i % 4) == 1);
         chk($sformatf("t2_c%0d_m1_ready", i), m1_ready_o, (i % 4) == 3);
         if ((i % 4) == 1) chk($sformatf("t2_c%0d_s_addr", i), s_addr_o, 32'h40);
         if ((i % 4) == 3) chk($sformatf("t2_c%0d_s_addr", i), s_addr_o, 32'h80);
      end
      m0_valid_i = 1'b0; m1_valid_i = 1'b0; s_ready_i = 1'b0;
      nxt();

      // m1 byte write
      m1_valid_i = 1'b1; m1_addr_i = 32'h2000; m1_wdata_i = 32'hAABB_CCDD; m1_we_i = 4'b0011;
      nxt(); settle();
      chk("t3_s_valid", s_valid_o, 1);
      chk("t3_s_addr", s_addr_o, 32'h2000);
      chk("t3_s_wdata", s_wdata_o, 32'hAABB_CCDD);
      chk("t3_s_we", s_we_o, 4'b0011);
      chk("t3_m1_ready_wait", m1_ready_o, 0);
      s_ready_i = 1'b1; settle();
      chk("t3_m1_ready", m1_ready_o, 1);
      chk("t3_m0_ready", m0_ready_o, 0);
      nxt();
      m1_valid_i = 1'b0; m1_we_i = 4'h0; s_ready_i = 1'b0; settle();
      chk("t3_after_m1_ready", m1_ready_o, 0);

      // Timeout after 4 waiting cycles
      m0_valid_i = 1'b1; m0_addr_i = 32'h300; s_rdata_i = 32'h1111_1111;
      nxt();
      for (int c = 1; c <= 5; c++) begin
         settle();
         chk($sformatf("t4_c%0d_err", c), err_o, c == 5);
         chk($sformatf("t4_c%0d_m0_ready", c), m0_ready_o, c == 5);
         chk($sformatf("t4_c%0d_s_valid", c), s_valid_o, c != 5);
         if (c == 5) chk("t4_rdata", m0_rdata_o, 32'hDEAD_BEEF);
         if (c < 5) nxt();
      end
      m0_valid_i = 1'b0;
      nxt(); settle();
      chk("t4_idle_s_valid", s_valid_o, 0);
      chk("t4_idle_err", err_o, 0);

      // Slave ready in the timeout cycle completes normally
      m0_valid_i = 1'b1;
      nxt(); nxt(); nxt(); nxt(); nxt();
      s_ready_i = 1'b1; s_rdata_i = 32'h55AA_55AA; settle();
      chk("t5_m0_ready", m0_ready_o, 1);
      chk("t5_err", err_o, 0);
      chk("t5_rdata", m0_rdata_o, 32'h55AA_55AA);
      nxt();
      m0_valid_i = 1'b0; s_ready_i = 1'b0;

      // m1 withdraws after one granted cycle, then m0 is served
      m1_valid_i = 1'b1; m1_addr_i = 32'h400;
      nxt(); settle();
      chk("t6_c1_s_valid", s_valid_o, 1);
      chk("t6_c1_s_addr", s_addr_o, 32'h400);
      nxt();
      m1_valid_i = 1'b0; m0_valid_i = 1'b1; m0_addr_i = 32'h500; s_ready_i = 1'b1; settle();
      chk("t6_c2_s_valid", s_valid_o, 0);
      chk("t6_c2_m1_ready", m1_ready_o, 0);
      chk("t6_c2_m0_ready", m0_ready_o, 0);
      chk("t6_c2_err", err_o, 0);
      nxt();
      s_ready_i = 1'b0; settle();
      chk("t6_c3_s_valid", s_valid_o, 0);
      nxt(); settle();
      chk("t6_c4_s_valid", s_valid_o, 1);
      chk("t6_c4_s_addr", s_addr_o, 32'h500);
      s_ready_i = 1'b1; settle();
      chk("t6_c4_m0_ready", m0_ready_o, 1);
      chk("t6_c4_m1_ready", m1_ready_o, 0);
      nxt();
      m0_valid_i = 1'b0; s_ready_i = 1'b0;

      // Reset pulse during GRANT0
      m0_valid_i = 1'b1; m0_addr_i = 32'h600;
      nxt(); settle();
      chk("t7_grant_s_valid", s_valid_o, 1);
      s_ready_i = 1'b1; rst_n = 1'b0; settle();
      chk("t7_rst_s_valid", s_valid_o, 0);
      chk("t7_rst_s_addr", s_addr_o, 0);
      chk("t7_rst_m0_ready", m0_ready_o, 0);
      chk("t7_rst_err", err_o, 0);
      nxt();
      rst_n = 1'b1; s_ready_i = 1'b0; settle();
      chk("t7_rel_s_valid", s_valid_o, 0);
      nxt(); settle();
      chk("t7_regrant_s_valid", s_valid_o, 1);
      chk("t7_regrant_s_addr", s_addr_o, 32'h600);
      s_ready_i = 1'b1; s_rdata_i = 32'h0BAD_F00D; settle();
      chk("t7_m0_ready", m0_ready_o, 1);
      chk("t7_m0_rdata", m0_rdata_o, 32'h0BAD_F00D);
      nxt();
      m0_valid_i = 1'b0; s_ready_i = 1'b0;
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, request address width.
REQ-002 Parameter DATA_WIDTH, default 32, write/read data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, wait cycles in a grant before the transaction is aborted (range 1..65535).
REQ-004 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 m0_valid_i / m1_valid_i  input  1  requester 0 (instruction side) / requester 1 (data side) request.
REQ-008 m0_ready_o / m1_ready_o  output  1  one-cycle completion strobe to each requester.
REQ-009 m0_addr_i / m1_addr_i  input  ADDR_WIDTH  request address.
REQ-010 m0_wdata_i / m1_wdata_i  input  DATA_WIDTH  write data.
REQ-011 m0_we_i / m1_we_i  input  4  byte write enables; all zero means read.
REQ-012 m0_rdata_o / m1_rdata_o  output  DATA_WIDTH  read data, valid only while the matching ready_o is high.
REQ-013 s_valid_o, s_addr_o, s_wdata_o, s_we_o  output  1/ADDR_WIDTH/DATA_WIDTH/4  request to the shared single-port slave.
REQ-014 s_ready_i, s_rdata_i  input  1/DATA_WIDTH  slave completion and read data.
REQ-015 err_o  output  1  one-cycle pulse when a transaction times out.

Function
REQ-016 FSM states: IDLE, GRANT0, GRANT1; one registered last_grant bit; one counter of ceil(log2(TIMEOUT_CYCLES+1)) bits.
REQ-017 Requesters hold valid, addr, wdata and we stable from assertion until their ready_o is high.
REQ-018 IDLE with exactly one valid: next state is the GRANT state of that requester.
REQ-019 IDLE with both valid: grant the requester not equal to last_grant (round-robin).
REQ-020 IDLE with no valid: stay in IDLE; s_valid_o=0, s_addr_o=0, s_wdata_o=0, s_we_o=0.
REQ-021 In GRANTn: s_valid_o = mn_valid_i; s_addr_o, s_wdata_o and s_we_o are combinationally muxed from requester n.
REQ-022 In GRANTn: mn_ready_o = s_ready_i; mn_rdata_o = s_rdata_i; the non-granted ready_o=0 and rdata_o=0.
REQ-023 Arbitration adds exactly one cycle: valid seen in IDLE at edge k gives s_valid_o high in cycle k+1.
REQ-024 s_ready_i in GRANTn: last_grant<=n, counter<=0, next state IDLE; the minimum back-to-back period per transaction is 2 cycles.
REQ-025 s_ready_i while s_valid_o=0 is ignored.
REQ-026 Granted requester drops valid before ready: s_valid_o falls in the same cycle, next state IDLE, last_grant unchanged, no ready_o and no err_o.
REQ-027 Counter increments each GRANT cycle without s_ready_i.
REQ-028 Counter reaching TIMEOUT_CYCLES without s_ready_i: in that cycle mn_ready_o=1, mn_rdata_o=ERR_DATA, err_o=1 and s_valid_o=0; then last_grant<=n and next state IDLE.
REQ-029 s_ready_i arriving in the timeout cycle wins: normal completion, no err_o.
REQ-030 Requester valid rising while the other requester is granted: it waits; it is granted at the next IDLE decision.
REQ-031 Under continuous contention, requester grants alternate strictly, so no requester waits more than one foreign transaction.

Reset
REQ-032 rst_n low: asynchronously force state=IDLE, last_grant=1 (requester 0 wins the first tie), counter=0.
REQ-033 During reset, all outputs are 0: s_valid_o, s_addr_o, s_wdata_o, s_we_o, m0/m1_ready_o, m0/m1_rdata_o and err_o.
REQ-034 Reset mid-transaction abandons it; no ready_o is produced for it after reset release.
REQ-035 First grant possible on the first clock edge after rst_n deasserts.

Verification
REQ-036 Stimulus: m0 read addr 0x100, slave ready 1 cycle after s_valid_o with rdata 0x12345678. Response: s_valid_o in cycle 1; m0_ready_o in cycle 2 with m0_rdata_o=0x12345678; m1_ready_o stays 0.
REQ-037 Stimulus: both valid from reset, slave always ready. Response: grant order m0, m1, m0, m1; each ready_o pulses once every 4 cycles.
REQ-038 Stimulus: m1 write we=4'b0011, addr 0x2000, wdata 0xAABBCCDD. Response: slave sees exact addr, wdata and we; m1_ready_o pulses once.
REQ-039 Stimulus: TIMEOUT_CYCLES=4, slave never ready, m0 read. Response: err_o and m0_ready_o high together 4 cycles after grant; m0_rdata_o=0xDEADBEEF; FSM returns to IDLE.
REQ-040 Stimulus: m1 drops valid after 1 granted cycle, then m0 requests. Response: no ready_o and no err_o for m1; m0 is granted next.
REQ-041 Stimulus: rst_n pulsed low during GRANT0. Response: all outputs 0 immediately; m0 is re-granted after release if still valid.
